// File: rtl/trace_filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trace_filter_ctrl
// Purpose  : Capture controller around trace_filter. Arms/starts/stops trace
//            capture on programmable PC triggers, applies the filter's
//            drop_instr verdict, buffers kept {pc,instr} items in a
//            first-word-fall-through FIFO with a valid/ready output, and keeps
//            saturating kept/dropped/overflow counters.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            pc, instr, pc_valid      - CPU trace port
//            drop_instr               - combinational filter verdict
//            cfg_wr/cfg_addr/cfg_wdata- config write port (0=CTRL,
//                                       1=TRIG_START, 2=TRIG_END, 3=reserved)
//            out_valid/out_ready/out_pc/out_instr - FIFO head handshake
//            state                    - 0=IDLE 1=ARMED 2=ACTIVE 3=DONE
//            overflow                 - sticky item-lost flag
//            kept_cnt/dropped_cnt/overflow_cnt - saturating event counters
// Revision : 1.0 - initial release
// ============================================================================
module trace_filter_ctrl #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     instr,
    input  logic            pc_valid,
    input  logic            drop_instr,
    input  logic            cfg_wr,
    input  logic [1:0]      cfg_addr,
    input  logic [XLEN-1:0] cfg_wdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [1:0]      state,
    output logic            overflow,
    output logic [31:0]     kept_cnt,
    output logic [31:0]     dropped_cnt,
    output logic [31:0]     overflow_cnt
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH + 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_armed  = 2'd1;
    localparam logic [1:0] c_st_active = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
    localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
    localparam logic [c_cw-1:0] c_full    = c_cw'(DEPTH);
    localparam logic [31:0]     c_sat     = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic            r_enable;
    logic            r_bypass;
    logic            r_start_en;
    logic            r_end_en;
    logic [XLEN-1:0] r_trig_start;
    logic [XLEN-1:0] r_trig_end;
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;

    logic w_cfg_open;
    logic w_ctrl_wr;
    logic w_tstart_wr;
    logic w_tend_wr;
    logic w_clear;

    // Trigger and mode fields may only change while capture is idle.
    assign w_cfg_open  = (r_state == c_st_idle);
    assign w_ctrl_wr   = cfg_wr && (cfg_addr == 2'd0);
    assign w_tstart_wr = cfg_wr && (cfg_addr == 2'd1);
    assign w_tend_wr   = cfg_wr && (cfg_addr == 2'd2);
    // Clear is a pulse, never stored: counters see it on the same edge.
    assign w_clear     = w_ctrl_wr && cfg_wdata[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable     <= 1'b0;
            r_bypass     <= 1'b0;
            r_start_en   <= 1'b0;
            r_end_en     <= 1'b0;
            r_trig_start <= '0;
            r_trig_end   <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_enable <= cfg_wdata[0];
                if (w_cfg_open) begin
                    r_bypass   <= cfg_wdata[1];
                    r_start_en <= cfg_wdata[2];
                    r_end_en   <= cfg_wdata[3];
                end
            end
            if (w_tstart_wr && w_cfg_open) begin
                r_trig_start <= cfg_wdata;
            end
            if (w_tend_wr && w_cfg_open) begin
                r_trig_end <= cfg_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture state machine
    // ------------------------------------------------------------------
    logic w_start_hit;
    logic w_end_hit;
    logic w_active;

    assign w_active    = (r_state == c_st_active);
    assign w_start_hit = r_enable && r_start_en && (r_state == c_st_armed) &&
                         pc_valid && (pc == r_trig_start);
    assign w_end_hit   = r_enable && r_end_en && w_active &&
                         pc_valid && (pc == r_trig_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!r_enable) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:   w_state_nxt = c_st_armed;
                c_st_armed: begin
                    if (!r_start_en || w_start_hit) begin
                        w_state_nxt = c_st_active;
                    end
                end
                c_st_active: begin
                    if (w_end_hit) begin
                        w_state_nxt = c_st_done;
                    end
                end
                default:     w_state_nxt = c_st_done;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Keep decision and FIFO
    // ------------------------------------------------------------------
    logic w_forced;
    logic w_keep;
    logic w_dropped;
    logic w_push;
    logic w_pop;
    logic w_lost;
    logic w_full;

    logic [XLEN-1:0] r_mem_pc    [DEPTH];
    logic [31:0]     r_mem_instr [DEPTH];
    logic [c_aw-1:0] r_wptr;
    logic [c_aw-1:0] r_rptr;
    logic [c_cw-1:0] r_count;

    // Trigger items are recorded even if the filter would drop them.
    assign w_forced  = w_start_hit || w_end_hit;
    assign w_keep    = pc_valid && (w_active || w_start_hit) &&
                       (r_bypass || !drop_instr || w_forced);
    assign w_dropped = pc_valid && w_active && !w_keep;

    assign w_full    = (r_count == c_full);
    assign w_pop     = out_valid && out_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign w_push    = w_keep && (!w_full || w_pop);
    assign w_lost    = w_keep && !w_push;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wptr]    <= pc;
            r_mem_instr[r_wptr] <= instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid = (r_count != '0);
    // Stale memory is masked so an empty FIFO shows zeros.
    assign out_pc    = out_valid ? r_mem_pc[r_rptr]    : '0;
    assign out_instr = out_valid ? r_mem_instr[r_rptr] : '0;
    assign state     = r_state;

    // ------------------------------------------------------------------
    // Saturating counters and sticky overflow
    // ------------------------------------------------------------------
    logic [31:0] r_kept_cnt;
    logic [31:0] r_dropped_cnt;
    logic [31:0] r_overflow_cnt;
    logic        r_overflow;

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_kept_cnt     <= '0;
            r_dropped_cnt  <= '0;
            r_overflow_cnt <= '0;
            r_overflow     <= 1'b0;
        end else begin
            if (w_push && (r_kept_cnt != c_sat)) begin
                r_kept_cnt <= r_kept_cnt + 32'd1;
            end
            if (w_dropped && (r_dropped_cnt != c_sat)) begin
                r_dropped_cnt <= r_dropped_cnt + 32'd1;
            end
            if (w_lost && (r_overflow_cnt != c_sat)) begin
                r_overflow_cnt <= r_overflow_cnt + 32'd1;
            end
            if (w_lost) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign kept_cnt     = r_kept_cnt;
    assign dropped_cnt  = r_dropped_cnt;
    assign overflow_cnt = r_overflow_cnt;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_trace_filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_filter_ctrl
// Purpose  : Self-checking bench for trace_filter_ctrl. Expected output items
//            are queued when stimulus is driven and compared as the FIFO head
//            is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_filter_ctrl;

    localparam int XLEN  = 64;
    localparam int DEPTH = 8;

    logic            clk;
    logic            rst;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            pc_valid;
    logic            drop_instr;
    logic            cfg_wr;
    logic [1:0]      cfg_addr;
    logic [XLEN-1:0] cfg_wdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [1:0]      state;
    logic            overflow;
    logic [31:0]     kept_cnt;
    logic [31:0]     dropped_cnt;
    logic [31:0]     overflow_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [95:0] sb[$];
    logic [95:0] exp_item;

    trace_filter_ctrl #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .instr        (instr),
        .pc_valid     (pc_valid),
        .drop_instr   (drop_instr),
        .cfg_wr       (cfg_wr),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .state        (state),
        .overflow     (overflow),
        .kept_cnt     (kept_cnt),
        .dropped_cnt  (dropped_cnt),
        .overflow_cnt (overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: a handshake seen at negedge is consumed on the next posedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_item", {63'd0, out_valid}, 64'd0);
            end else begin
                exp_item = sb.pop_front();
                check("out_pc", out_pc, exp_item[95:32]);
                check("out_instr", {32'd0, out_instr}, {32'd0, exp_item[31:0]});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [63:0] data);
        cfg_wr    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick(1);
        cfg_wr    = 1'b0;
    endtask

    task automatic drive_item(input logic [63:0] p, input logic [31:0] ins,
                              input logic drop, input logic expect_keep);
        if (expect_keep) sb.push_back({p, ins});
        pc         = p;
        instr      = ins;
        drop_instr = drop;
        pc_valid   = 1'b1;
        tick(1);
        pc_valid   = 1'b0;
        drop_instr = 1'b0;
    endtask

    // Disable, then wait until the FSM has settled in IDLE.
    task automatic go_idle();
        cfg_write(2'd0, 64'd0);
        tick(1);
        check("idle_state", {62'd0, state}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pc = '0; instr = '0; pc_valid = 1'b0; drop_instr = 1'b0;
        cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0; out_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_state",     {62'd0, state}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_pc",    out_pc, 64'd0);
        check("rst_kept",      {32'd0, kept_cnt}, 64'd0);
        check("rst_overflow",  {63'd0, overflow}, 64'd0);

        // Test 1: plain capture with the filter deciding.
        out_ready = 1'b1;
        cfg_write(2'd0, 64'h1);
        tick(2);
        check("t1_active", {62'd0, state}, 64'd2);
        drive_item(64'h1000, 32'h6f, 1'b0, 1'b1);
        drive_item(64'h1004, 32'h13, 1'b1, 1'b0);
        drive_item(64'h1008, 32'h67, 1'b0, 1'b1);
        tick(3);
        check("t1_kept",    {32'd0, kept_cnt}, 64'd2);
        check("t1_dropped", {32'd0, dropped_cnt}, 64'd1);

        // Test 2: start trigger.
        go_idle();
        cfg_write(2'd1, 64'h8000_0010);
        cfg_write(2'd0, 64'h5);
        tick(2);
        check("t2_armed", {62'd0, state}, 64'd1);
        drive_item(64'h8000_0000, 32'h100, 1'b0, 1'b0);
        drive_item(64'h8000_0008, 32'h108, 1'b0, 1'b0);
        check("t2_still_armed", {62'd0, state}, 64'd1);
        drive_item(64'h8000_0010, 32'h110, 1'b1, 1'b1);
        check("t2_active", {62'd0, state}, 64'd2);
        drive_item(64'h8000_0014, 32'h114, 1'b0, 1'b1);
        tick(3);
        check("t2_kept",    {32'd0, kept_cnt}, 64'd4);
        check("t2_dropped", {32'd0, dropped_cnt}, 64'd1);

        // Test 3: end trigger.
        go_idle();
        cfg_write(2'd2, 64'h8000_0020);
        cfg_write(2'd0, 64'h9);
        tick(2);
        check("t3_active", {62'd0, state}, 64'd2);
        drive_item(64'h8000_0018, 32'h118, 1'b1, 1'b0);
        drive_item(64'h8000_0020, 32'h120, 1'b1, 1'b1);
        check("t3_done", {62'd0, state}, 64'd3);
        drive_item(64'h8000_0024, 32'h124, 1'b1, 1'b0);
        drive_item(64'h8000_0028, 32'h128, 1'b0, 1'b0);
        tick(3);
        check("t3_kept",    {32'd0, kept_cnt}, 64'd5);
        check("t3_dropped", {32'd0, dropped_cnt}, 64'd2);

        // Clear honoured outside IDLE.
        cfg_write(2'd0, 64'h11);
        check("clr_kept",    {32'd0, kept_cnt}, 64'd0);
        check("clr_dropped", {32'd0, dropped_cnt}, 64'd0);
        check("clr_state",   {62'd0, state}, 64'd3);

        // Test 4: overflow with a stalled consumer.
        go_idle();
        cfg_write(2'd0, 64'h1);
        tick(2);
        out_ready = 1'b0;
        drive_item(64'h2000, 32'h200, 1'b0, 1'b1);
        check("t4_latency_valid", {63'd0, out_valid}, 64'd1);
        check("t4_latency_pc",    out_pc, 64'h2000);
        for (int i = 1; i < 10; i++) begin
            drive_item(64'h2000 + 64'(4 * i), 32'h200 + 32'(i), 1'b0, i < DEPTH);
        end
        check("t4_ovf_cnt", {32'd0, overflow_cnt}, 64'd2);
        check("t4_ovf",     {63'd0, overflow}, 64'd1);
        check("t4_kept",    {32'd0, kept_cnt}, 64'd8);

        // Test 5: push into a full FIFO while the head leaves.
        out_ready = 1'b1;
        drive_item(64'h2028, 32'h20a, 1'b0, 1'b1);
        check("t5_ovf_cnt", {32'd0, overflow_cnt}, 64'd2);
        check("t5_kept",    {32'd0, kept_cnt}, 64'd9);
        tick(12);
        check("t5_drained", {63'd0, out_valid}, 64'd0);
        check("t5_sb_left", 64'(sb.size()), 64'd0);

        // Test 6: TRIG_START write outside IDLE is ignored, then reset mid-drain.
        cfg_write(2'd1, 64'h1234);
        go_idle();
        cfg_write(2'd0, 64'h5);
        tick(2);
        drive_item(64'h1234, 32'h300, 1'b0, 1'b0);
        check("t6_ignored_trig", {62'd0, state}, 64'd1);
        drive_item(64'h8000_0010, 32'h310, 1'b1, 1'b1);
        check("t6_orig_trig", {62'd0, state}, 64'd2);
        out_ready = 1'b0;
        drive_item(64'h3000, 32'h320, 1'b0, 1'b1);
        drive_item(64'h3004, 32'h321, 1'b0, 1'b1);
        drive_item(64'h3008, 32'h322, 1'b0, 1'b1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        rst = 1'b1;
        tick(1);
        check("t6_rst_valid",   {63'd0, out_valid}, 64'd0);
        check("t6_rst_state",   {62'd0, state}, 64'd0);
        check("t6_rst_kept",    {32'd0, kept_cnt}, 64'd0);
        check("t6_rst_dropped", {32'd0, dropped_cnt}, 64'd0);
        check("t6_rst_ovf_cnt", {32'd0, overflow_cnt}, 64'd0);
        check("t6_rst_ovf",     {63'd0, overflow}, 64'd0);
        sb.delete();
        rst = 1'b0;
        out_ready = 1'b1;
        tick(3);
        check("t6_post_state", {62'd0, state}, 64'd0);
        check("t6_post_valid", {63'd0, out_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
